cache_port_arbiter: RTL

// - Shares the single cache controller between two requesters (port 0 = fetch, port 1 = data).
// - Round-robin grant. Captures the winning request and drives the controller's ctrl/indirect/addr/dataIn for the whole transaction.
// - Returns read data, an ack pulse and an error flag to the granted port.
// - Sits between the pipeline's memory stages and the cache controller.

---
 rtl/cache_port_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: round-robin share of one cache controller between fetch (port 0) and data (port 1); clk/reset, req/ctrl/ind/addr/wdata per port in, ack/rdata/err/grant out, cache* drive the controller
module cache_port_arbiter #(
  parameter int ramWidth = 8,
  parameter int addrSize = 8,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0,
  input  logic                req1,
  input  logic [1:0]          ctrl0,
  input  logic [1:0]          ctrl1,
  input  logic                ind0,
  input  logic                ind1,
  input  logic [addrSize-1:0] addr0,
  input  logic [addrSize-1:0] addr1,
  input  logic [ramWidth-1:0] wdata0,
  input  logic [ramWidth-1:0] wdata1,
  output logic                ack0,
  output logic                ack1,
  output logic [ramWidth-1:0] rdata,
  output logic                err,
  output logic [1:0]          grant,
  output logic [1:0]          cacheCtrl,
  output logic                cacheIndirect,
  output logic [addrSize-1:0] cacheAddr,
  output logic [ramWidth-1:0] cacheDataIn,
  input  logic                cacheIdle,
  input  logic                outputReady,
  input  logic [ramWidth-1:0] cacheDataOut
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, nxt;
  logic last, win, go, done_ok, tmo;
  logic [1:0] sel_ctrl, cap_ctrl;
  logic cap_ind;
  logic [addrSize-1:0] cap_addr;
  logic [ramWidth-1:0] cap_wdata;
  logic [CW-1:0] cnt;
  assign go = (req0 | req1) & cacheIdle;
  // on a tie the port that did not go last wins
  assign win = (req0 & req1) ? ~last : req1;
  assign sel_ctrl = win ? ctrl1 : ctrl0;
  // read/write completes on outputReady; clear completes when the controller is back in start
  assign done_ok = cap_ctrl[1] ? outputReady : cacheIdle;
  assign tmo = cnt == CW'(TIMEOUT - 1);
  // clear is driven only during ISSUE so the controller in start never re-launches it
  assign cacheCtrl = (state == ISSUE || (state == WAIT && cap_ctrl[1])) ? cap_ctrl : 2'b01;
  assign cacheIndirect = cap_ind;
  assign cacheAddr = cap_addr;
  assign cacheDataIn = cap_wdata;
  assign ack0 = state == DONE && grant[0];
  assign ack1 = state == DONE && grant[1];
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = go ? (sel_ctrl == 2'b01 ? DONE : ISSUE) : IDLE;
      ISSUE:   nxt = WAIT;
      WAIT:    nxt = (done_ok || tmo) ? DONE : WAIT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last <= 1'b1;
      grant <= '0;
      cap_ctrl <= '0;
      cap_ind <= 1'b0;
      cap_addr <= '0;
      cap_wdata <= '0;
      cnt <= '0;
      rdata <= '0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      if (state == IDLE && go) begin
        grant <= win ? 2'b10 : 2'b01;
        cap_ctrl <= sel_ctrl;
        cap_ind <= win ? ind1 : ind0;
        cap_addr <= win ? addr1 : addr0;
        cap_wdata <= win ? wdata1 : wdata0;
        rdata <= '0;
        err <= 1'b0;
      end
      if (state == WAIT && done_ok) begin
        rdata <= cap_ctrl[1] ? cacheDataOut : '0;
        err <= 1'b0;
      end else if (state == WAIT && tmo) begin
        rdata <= '0;
        err <= 1'b1;
      end
      if (state == DONE) begin
        last <= grant[1];
        grant <= '0;
      end
    end
  end
endmodule
